// File: rtl/i2c_target_device.sv
// ---------------------------------------------------------------------------
// i2c_target_device
//   7-bit-address I2C target (responder). SCL and SDA are oversampled on clk,
//   START / repeated START / STOP are detected from the synchronised pins, and
//   a two-process FSM ACKs its own address, hands written bytes to the fabric
//   and shifts read bytes supplied by the fabric back onto the bus.
//   No clock stretching: clk must run at least 10x the SCL frequency.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   scl_in     in   raw SCL pin level (asynchronous)
//   sda_in     in   raw SDA pin level (asynchronous)
//   sda_oe     out  1 = pull SDA low, 0 = release (open-drain pad is external)
//   rx_data    out  last byte written by the initiator
//   rx_valid   out  one-cycle pulse, rx_data is new
//   tx_req     out  one-cycle pulse, fabric must present the next read byte
//   tx_data    in   read byte, sampled on the SCL fall that starts the byte
//   addressed  out  high from address ACK until STOP, NACK or next START
//   rw         out  R/W bit of the current transfer (1 = read)
// ---------------------------------------------------------------------------
module i2c_target_device #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       addressed,
  output logic       rw
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX_BYTE  = 3'd3,
    RX_ACK   = 3'd4,
    TX_BYTE  = 3'd5,
    TX_ACK   = 3'd6
  } state_t;

  // Synchroniser and edge-history flops. They reset to the idle bus level (1)
  // so that leaving reset on an idle bus creates no false edge.
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  logic scl_rise_s, scl_fall_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;
  logic [7:0] byte_in_s;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       load_q, load_d;
  logic       sda_oe_q, sda_oe_d;
  logic       addressed_q, addressed_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  // Two-flop synchroniser plus previous-value register on each pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // Single-cycle edge pulses and bus conditions. SDA moving while SCL is
  // high can only be a START (fall) or STOP (rise).
  always_comb begin
    scl_rise_s = scl_sync_q & ~scl_prev_q;
    scl_fall_s = ~scl_sync_q & scl_prev_q;
    sda_rise_s = sda_sync_q & ~sda_prev_q;
    sda_fall_s = ~sda_sync_q & sda_prev_q;
    start_s    = sda_fall_s & scl_sync_q;
    stop_s     = sda_rise_s & scl_sync_q;
    // Byte as it will look once the bit arriving on this SCL rise is shifted in.
    byte_in_s  = {shift_q[6:0], sda_sync_q};
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      tx_shift_q  <= 8'h00;
      load_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      load_q      <= load_d;
      sda_oe_q    <= sda_oe_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
    end
  end

  // Next-state and output logic. START/STOP override every state; all SDA
  // drive changes otherwise happen only on an SCL fall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    load_d      = load_q;
    sda_oe_d    = sda_oe_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;

    if (start_s) begin
      state_d     = ADDR;
      cnt_d       = 4'd0;
      shift_d     = 8'h00;
      load_d      = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_s) begin
      state_d     = IDLE;
      cnt_d       = 4'd0;
      load_d      = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = 4'd0;
        end

        ADDR: begin
          if (scl_rise_s) begin
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (byte_in_s[7:1] == DEV_ADDR) begin
                rw_d     = byte_in_s[0];
                tx_req_d = byte_in_s[0];
                state_d  = ADDR_ACK;
              end else begin
                state_d = IDLE;
              end
            end else begin
              shift_d = byte_in_s;
              cnt_d   = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        // cnt 0: waiting for the fall that starts the ACK bit.
        // cnt 1: waiting for the fall that ends it.
        ADDR_ACK: begin
          if (scl_fall_s) begin
            if (cnt_q == 4'd0) begin
              sda_oe_d    = 1'b1;
              addressed_d = 1'b1;
              cnt_d       = 4'd1;
            end else if (rw_q) begin
              tx_shift_d = {tx_data[6:0], 1'b0};
              sda_oe_d   = ~tx_data[7];
              load_d     = 1'b0;
              cnt_d      = 4'd0;
              state_d    = TX_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              shift_d  = 8'h00;
              cnt_d    = 4'd0;
              state_d  = RX_BYTE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        RX_BYTE: begin
          if (scl_rise_s) begin
            if (cnt_q == 4'd7) begin
              rx_data_d  = byte_in_s;
              rx_valid_d = 1'b1;
              cnt_d      = 4'd0;
              state_d    = RX_ACK;
            end else begin
              shift_d = byte_in_s;
              cnt_d   = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        RX_ACK: begin
          if (scl_fall_s) begin
            if (cnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
              cnt_d    = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              shift_d  = 8'h00;
              cnt_d    = 4'd0;
              state_d  = RX_BYTE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        // Bit 7 of a byte is already on the bus when this state is entered
        // from ADDR_ACK; after an initiator ACK (load_q) the first fall loads
        // and drives the new byte. cnt counts the bits 6..0 driven so far.
        TX_BYTE: begin
          if (scl_fall_s) begin
            if (load_q) begin
              tx_shift_d = {tx_data[6:0], 1'b0};
              sda_oe_d   = ~tx_data[7];
              load_d     = 1'b0;
              cnt_d      = 4'd0;
            end else if (cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = TX_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              cnt_d      = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        TX_ACK: begin
          if (scl_rise_s) begin
            cnt_d = 4'd0;
            if (!sda_sync_q) begin
              tx_req_d = 1'b1;
              load_d   = 1'b1;
              state_d  = TX_BYTE;
            end else begin
              addressed_d = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = IDLE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        default: begin
          state_d     = IDLE;
          cnt_d       = 4'd0;
          sda_oe_d    = 1'b0;
          addressed_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign addressed = addressed_q;
  assign rw        = rw_q;

endmodule

// File: tb/tb_i2c_target_device.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_device
//   Bench for i2c_target_device. A bit-banged initiator drives SCL/SDA over a
//   wired-AND bus; expected ACKs, received bytes, read bytes and tx_req counts
//   come from transaction-level rules (address match, direction, byte list).
// ---------------------------------------------------------------------------
module tb_i2c_target_device;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda, force_hi;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       addressed;
  logic       rw;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Monitor-owned observations.
  logic [7:0] rx_seen[$];
  int         tx_req_cnt = 0;
  int         oe_cycles  = 0;

  // Bench-owned model state.
  logic [7:0] exp_rx[$];
  int         rx_base = 0;
  logic [7:0] data_buf[9];

  always #5 clk = ~clk;

  // Open-drain bus; force_hi models an external driver overpowering SDA.
  assign scl_in = m_scl;
  assign sda_in = force_hi ? 1'b1 : (m_sda & ~sda_oe);

  i2c_target_device #(.DEV_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .tx_data(tx_data),
    .addressed(addressed), .rw(rw)
  );

  always @(negedge clk) begin
    if (rx_valid) rx_seen.push_back(rx_data);
    if (tx_req) tx_req_cnt++;
    if (sda_oe) oe_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic send_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic bit_out(input logic b);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bit_in(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = sda_in;   tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic byte_out(input logic [7:0] d, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(x);
    ack = ~x;
  endtask

  task automatic byte_in(output logic [7:0] d, input logic ack, input logic [7:0] next_tx);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      bit_in(x);
      d[i] = x;
    end
    tx_data = next_tx;
    bit_out(~ack);
  endtask

  // One address phase plus n data bytes from data_buf (no STOP).
  task automatic run_xfer(input logic [6:0] addr, input logic rd, input int n);
    logic       match, ack;
    logic [7:0] got;
    int         txb, oeb;
    match = (addr == 7'h42);
    txb   = tx_req_cnt;
    oeb   = oe_cycles;
    tx_data = data_buf[0];
    send_start();
    byte_out({addr, rd}, ack);
    check_eq("addr_ack", ack, match);
    check_eq("addressed", addressed, match);
    if (match) check_eq("rw", rw, rd);
    for (int i = 0; i < n; i++) begin
      if (rd) begin
        byte_in(got, (i != n - 1), data_buf[i + 1]);
        check_eq("rd_byte", got, match ? data_buf[i] : 8'hFF);
      end else begin
        byte_out(data_buf[i], ack);
        check_eq("wr_ack", ack, match);
        if (match) exp_rx.push_back(data_buf[i]);
      end
    end
    check_eq("tx_req_cnt", tx_req_cnt - txb, (match && rd) ? n : 0);
    if (rd && match) check_eq("addressed_after_nack", addressed, 1'b0);
    if (!match) check_eq("oe_quiet", oe_cycles - oeb, 0);
  endtask

  task automatic end_xfer();
    int got_n;
    send_stop();
    check_eq("addressed_stop", addressed, 1'b0);
    check_eq("oe_stop", sda_oe, 1'b0);
    got_n = rx_seen.size() - rx_base;
    check_eq("rx_count", got_n, exp_rx.size());
    for (int i = 0; i < got_n && i < exp_rx.size(); i++)
      check_eq("rx_data", rx_seen[rx_base + i], exp_rx[i]);
    rx_base = rx_seen.size();
    exp_rx.delete();
  endtask

  initial begin
    logic       ack, x;
    logic [6:0] a;
    int         oeb, txb;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; force_hi = 1'b0; tx_data = 8'h00;
    tick(3);
    check_eq("reset_outs", {sda_oe, rx_data, rx_valid, tx_req, addressed, rw}, 13'h0);
    rst = 1'b0;
    tick(5);

    // Write 0xA5 to our address.
    data_buf[0] = 8'hA5;
    run_xfer(7'h42, 1'b0, 1);
    end_xfer();

    // Read 0x3C (ACK) then 0xF0 (NACK).
    data_buf[0] = 8'h3C; data_buf[1] = 8'hF0; data_buf[2] = 8'h00;
    run_xfer(7'h42, 1'b1, 2);
    end_xfer();

    // Wrong address 0x43 with data 0xFF.
    data_buf[0] = 8'hFF;
    run_xfer(7'h43, 1'b0, 1);
    end_xfer();

    // Write 0x11, repeated START, read 0x7E.
    data_buf[0] = 8'h11;
    run_xfer(7'h42, 1'b0, 1);
    check_eq("rw_write", rw, 1'b0);
    data_buf[0] = 8'h7E; data_buf[1] = 8'h00;
    run_xfer(7'h42, 1'b1, 1);
    check_eq("rw_read", rw, 1'b1);
    end_xfer();

    // Randomised transfers.
    for (int t = 0; t < 8; t++) begin
      int n;
      logic rd;
      if ($urandom_range(0, 2) != 0) a = 7'h42;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h42) a = 7'h11;
      end
      rd = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 4);
      for (int i = 0; i < 9; i++) data_buf[i] = 8'($urandom);
      run_xfer(a, rd, n);
      end_xfer();
    end

    // STOP forced during the 4th bit of a read of 0x00.
    txb = tx_req_cnt;
    tx_data = 8'h00;
    send_start();
    byte_out({7'h42, 1'b1}, ack);
    check_eq("stop_rd_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) bit_in(x);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    check_eq("stop_rd_driving", sda_oe, 1'b1);
    force_hi = 1'b1;
    tick(4);
    check_eq("stop_rd_release", sda_oe, 1'b0);
    check_eq("stop_rd_addressed", addressed, 1'b0);
    check_eq("stop_rd_txreq", tx_req_cnt - txb, 1);
    m_sda = 1'b1;
    force_hi = 1'b0;
    tick(Q);
    oeb = oe_cycles;
    for (int i = 0; i < 9; i++) bit_out(1'b1);
    m_scl = 1'b1;
    tick(Q);
    check_eq("idle_quiet", oe_cycles - oeb, 0);

    // Reset during an address ACK, then a normal write.
    send_start();
    for (int i = 7; i >= 0; i--) bit_out(i == 0 ? 1'b0 : ((8'h84 >> i) & 8'h01) != 8'h00);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    check_eq("rst_ack_driving", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_release", sda_oe, 1'b0);
    tick(Q);
    m_scl = 1'b0;
    tick(2);
    check_eq("rst_addressed", addressed, 1'b0);
    rst = 1'b0;
    tick(Q);
    rx_base = rx_seen.size();
    data_buf[0] = 8'($urandom);
    run_xfer(7'h42, 1'b0, 1);
    end_xfer();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
